// File: rtl/arbitro_contador_pkg.sv
// Shared encodings for the two-requester counter arbiter: counter modes,
// controller states and requester indices.
package arbitro_contador_pkg;

    typedef enum logic [1:0] {
        MODO_UP   = 2'b00,
        MODO_DN1  = 2'b01,
        MODO_DN3  = 2'b10,
        MODO_LOAD = 2'b11
    } modo_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_COUNT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam logic REQ_A_IDX = 1'b0;
    localparam logic REQ_B_IDX = 1'b1;

endpackage

// File: rtl/arbitro_contador_rr2.sv
// Two-input round-robin picker; the pointer names the requester that wins
// when both ask at once and moves to the other side when an owner is released.
module arbitro_rr2
    import arbitro_contador_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_adv,
    input  logic i_owner,
    output logic o_vld,
    output logic o_pick
);

    logic r_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= REQ_A_IDX;
        end else if (i_adv) begin
            r_ptr <= ~i_owner;
        end
    end

    always_comb begin
        o_vld  = i_req_a | i_req_b;
        o_pick = (i_req_a && i_req_b) ? r_ptr : i_req_b;
    end

endmodule

// File: rtl/arbitro_contador.sv
// Shares one up/down counter between requesters A and B: grant, load VAL,
// count down to zero, pulse DONE, release; a watchdog aborts a stuck count.
module arbitro_contador
    import arbitro_contador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WDOG  = 20
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             REQ_A,
    input  logic             REQ_B,
    input  logic [WIDTH-1:0] VAL_A,
    input  logic [WIDTH-1:0] VAL_B,
    input  logic             STEP3_A,
    input  logic             STEP3_B,
    input  logic [WIDTH-1:0] Q,
    output logic             GNT_A,
    output logic             GNT_B,
    output logic             DONE_A,
    output logic             DONE_B,
    output logic             ERR,
    output logic             ENB,
    output logic [1:0]       MODO,
    output logic [WIDTH-1:0] D
);

    localparam int WDW = $clog2(WDOG + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG - 1);

    state_e           r_state;
    logic             r_owner;
    logic [WIDTH-1:0] r_val;
    logic             r_step3;
    logic [WDW-1:0]   r_wdog;
    logic             r_err;

    state_e w_state_nxt;
    modo_e  w_modo;
    logic   w_enb;
    logic   w_grant;
    logic   w_release;
    logic   w_err;
    logic   w_pick_vld;
    logic   w_pick;
    logic   w_owner_req;

    arbitro_rr2 u_rr (
        .i_clk   (CLK),
        .i_rst_n (RESET_L),
        .i_req_a (REQ_A),
        .i_req_b (REQ_B),
        .i_adv   (w_release),
        .i_owner (r_owner),
        .o_vld   (w_pick_vld),
        .o_pick  (w_pick)
    );

    assign w_owner_req = (r_owner == REQ_B_IDX) ? REQ_B : REQ_A;

    // Counter drive depends only on state, latched data and Q, never on REQ.
    always_comb begin
        w_enb  = 1'b0;
        w_modo = MODO_UP;
        case (r_state)
            ST_LOAD: begin
                w_enb  = 1'b1;
                w_modo = MODO_LOAD;
            end
            ST_COUNT: begin
                if (Q != '0) begin
                    w_enb  = 1'b1;
                    w_modo = (r_step3 && (Q >= WIDTH'(3))) ? MODO_DN3 : MODO_DN1;
                end
            end
            default: begin
                w_enb  = 1'b0;
                w_modo = MODO_UP;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_release   = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!w_owner_req) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (!w_owner_req) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (Q == '0) begin
                    w_state_nxt = ST_DONE;
                end else if (r_wdog == WDOG_LAST) begin
                    w_err       = 1'b1;
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_release   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            r_state <= ST_IDLE;
            r_owner <= REQ_A_IDX;
            r_val   <= '0;
            r_step3 <= 1'b0;
            r_wdog  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err;
            r_wdog  <= (r_state == ST_COUNT) ? r_wdog + WDW'(1) : '0;
            if (w_grant) begin
                r_owner <= w_pick;
                r_val   <= (w_pick == REQ_B_IDX) ? VAL_B : VAL_A;
                r_step3 <= (w_pick == REQ_B_IDX) ? STEP3_B : STEP3_A;
            end
        end
    end

    assign GNT_A  = (r_state != ST_IDLE) && (r_owner == REQ_A_IDX);
    assign GNT_B  = (r_state != ST_IDLE) && (r_owner == REQ_B_IDX);
    assign DONE_A = (r_state == ST_DONE) && (r_owner == REQ_A_IDX);
    assign DONE_B = (r_state == ST_DONE) && (r_owner == REQ_B_IDX);
    assign ERR    = r_err;
    assign ENB    = w_enb;
    assign MODO   = w_modo;
    assign D      = r_val;

endmodule

// File: tb/tb_arbitro_contador.sv
// Bench for arbitro_contador with a behavioural counter (optionally stuck at 9)
// and a scoreboard of expected DONE/ERR pulses keyed by edge number.
module tb_arbitro_contador;
    import arbitro_contador_pkg::*;

    localparam int WIDTH = 4;
    localparam int WDOG  = 20;

    localparam logic [2:0] EV_DA  = 3'b001;
    localparam logic [2:0] EV_DB  = 3'b010;
    localparam logic [2:0] EV_ERR = 3'b100;

    logic             CLK = 1'b0;
    logic             RESET_L = 1'b1;
    logic             REQ_A = 1'b0, REQ_B = 1'b0;
    logic             STEP3_A = 1'b0, STEP3_B = 1'b0;
    logic [WIDTH-1:0] VAL_A = '0, VAL_B = '0;
    logic [WIDTH-1:0] q = '0;
    logic             GNT_A, GNT_B, DONE_A, DONE_B, ERR, ENB;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] D;
    logic             stuck = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int g;

    typedef struct packed {
        logic [2:0] kind;
        int         cyc;
    } ev_t;
    ev_t sb[$];

    arbitro_contador #(.WIDTH(WIDTH), .WDOG(WDOG)) dut (
        .CLK     (CLK),
        .RESET_L (RESET_L),
        .REQ_A   (REQ_A),
        .REQ_B   (REQ_B),
        .VAL_A   (VAL_A),
        .VAL_B   (VAL_B),
        .STEP3_A (STEP3_A),
        .STEP3_B (STEP3_B),
        .Q       (q),
        .GNT_A   (GNT_A),
        .GNT_B   (GNT_B),
        .DONE_A  (DONE_A),
        .DONE_B  (DONE_B),
        .ERR     (ERR),
        .ENB     (ENB),
        .MODO    (MODO),
        .D       (D)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Counter model; no reset, as the real counter keeps Q across arbiter resets.
    always @(posedge CLK) begin
        if (stuck) begin
            q <= 4'd9;
        end else if (ENB) begin
            case (MODO)
                2'b00:   q <= q + 4'd1;
                2'b01:   q <= q - 4'd1;
                2'b10:   q <= q - 4'd3;
                default: q <= D;
            endcase
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic void expect_ev(input logic [2:0] k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        sb.push_back(e);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {20'd0, GNT_A, GNT_B, DONE_A, DONE_B, ERR, ENB, MODO, D}, 32'd0);
    endtask

    always @(negedge CLK) begin
        if (RESET_L && (DONE_A || DONE_B || ERR)) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pulse observed=%b@%0d expected=none", {ERR, DONE_B, DONE_A}, cyc);
            end
            if (sb.size() != 0) begin
                ev_t e;
                e = sb.pop_front();
                assert ({ERR, DONE_B, DONE_A, cyc} === {e.kind, e.cyc}) else begin
                    errors++;
                    $error("FAIL pulse observed=%b@%0d expected=%b@%0d",
                           {ERR, DONE_B, DONE_A}, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    initial begin
        // Asynchronous reset mid-cycle, then release.
        #2 RESET_L = 1'b0;
        #1 chk_zero("rst_async");
        chk("rst_modo", {30'd0, MODO}, 32'd0);
        #9 RESET_L = 1'b1;
        tick();
        chk("idle_gnt", {30'd0, GNT_A, GNT_B}, 32'd0);
        chk("idle_enb", {31'd0, ENB}, 32'd0);

        // A: VAL=5 step-by-1.
        REQ_A = 1'b1; VAL_A = 4'd5; STEP3_A = 1'b0;
        g = cyc + 1;
        expect_ev(EV_DA, g + 7);
        tick();
        chk("a_gnt", {31'd0, GNT_A}, 32'd1);
        chk("a_load_modo", {30'd0, MODO}, 32'd3);
        chk("a_load_d", {28'd0, D}, 32'd5);
        chk("a_load_enb", {31'd0, ENB}, 32'd1);
        tick();
        chk("a_q5", {28'd0, q}, 32'd5);
        chk("a_modo", {30'd0, MODO}, 32'd1);
        for (int i = 4; i >= 1; i--) begin
            tick();
            chk("a_q", {28'd0, q}, i);
            chk("a_modo", {30'd0, MODO}, 32'd1);
        end
        tick();
        chk("a_q0", {28'd0, q}, 32'd0);
        chk("a_enb0", {31'd0, ENB}, 32'd0);
        chk("a_gnt_held", {31'd0, GNT_A}, 32'd1);
        tick();
        chk("a_done", {31'd0, DONE_A}, 32'd1);
        REQ_A = 1'b0;
        tick();
        chk("a_release", {30'd0, GNT_A, DONE_A}, 32'd0);

        // B: VAL=7 step-by-3 -> Q 7,4,1,0.
        REQ_B = 1'b1; VAL_B = 4'd7; STEP3_B = 1'b1;
        g = cyc + 1;
        expect_ev(EV_DB, g + 5);
        tick();
        chk("b_gnt", {30'd0, GNT_A, GNT_B}, 32'd1);
        chk("b_load_d", {28'd0, D}, 32'd7);
        tick(); chk("b_q7", {28'd0, q}, 32'd7); chk("b_m7", {30'd0, MODO}, 32'd2);
        tick(); chk("b_q4", {28'd0, q}, 32'd4); chk("b_m4", {30'd0, MODO}, 32'd2);
        tick(); chk("b_q1", {28'd0, q}, 32'd1); chk("b_m1", {30'd0, MODO}, 32'd1);
        tick(); chk("b_q0", {28'd0, q}, 32'd0); chk("b_enb0", {31'd0, ENB}, 32'd0);
        tick(); chk("b_done", {31'd0, DONE_B}, 32'd1);
        REQ_B = 1'b0;
        tick(); chk("b_release", {31'd0, GNT_B}, 32'd0);

        // Simultaneous requests from reset; VAL_A = 0.
        #2 RESET_L = 1'b0;
        #1;
        #2 RESET_L = 1'b1;
        REQ_A = 1'b1; REQ_B = 1'b1; VAL_A = 4'd0; VAL_B = 4'd2;
        STEP3_A = 1'b0; STEP3_B = 1'b0;
        g = cyc + 1;
        expect_ev(EV_DA, g + 2);
        expect_ev(EV_DB, g + 8);
        expect_ev(EV_DA, g + 12);
        tick(); chk("sim_first_a", {30'd0, GNT_A, GNT_B}, 32'd2);
        tick(); chk("sim_a0_enb", {31'd0, ENB}, 32'd0);
        tick(); chk("sim_a0_done", {31'd0, DONE_A}, 32'd1);
        tick(); chk("sim_idle1", {30'd0, GNT_A, GNT_B}, 32'd0);
        tick(); chk("sim_then_b", {30'd0, GNT_A, GNT_B}, 32'd1);
        repeat (4) tick();
        chk("sim_b_done", {31'd0, DONE_B}, 32'd1);
        tick(); chk("sim_idle2", {30'd0, GNT_A, GNT_B}, 32'd0);
        tick(); chk("sim_again_a", {30'd0, GNT_A, GNT_B}, 32'd2);
        tick();
        tick(); chk("sim_a_done2", {31'd0, DONE_A}, 32'd1);
        REQ_A = 1'b0; REQ_B = 1'b0;
        tick(); chk("sim_idle3", {30'd0, GNT_A, GNT_B}, 32'd0);

        // Abort A at Q=3 with B pending.
        REQ_A = 1'b1; VAL_A = 4'd6;
        tick(); chk("ab_gnt_a", {31'd0, GNT_A}, 32'd1);
        REQ_B = 1'b1; VAL_B = 4'd2;
        repeat (4) tick();
        chk("ab_q3", {28'd0, q}, 32'd3);
        REQ_A = 1'b0;
        tick(); chk("ab_dropped", {28'd0, GNT_A, GNT_B, ENB, DONE_A}, 32'd0);
        tick(); chk("ab_b_gnt", {30'd0, GNT_A, GNT_B}, 32'd1);

        // Reset while B is counting; pointer must return to A.
        tick();
        #2 RESET_L = 1'b0;
        #1 chk_zero("rst_mid");
        chk("rst_q_kept", {28'd0, q}, 32'd2);
        #2 RESET_L = 1'b1;
        REQ_A = 1'b1;
        tick(); chk("rst_ptr_a", {30'd0, GNT_A, GNT_B}, 32'd2);
        REQ_A = 1'b0; REQ_B = 1'b0;
        tick(); chk("ab_in_load", {29'd0, GNT_A, GNT_B, DONE_A}, 32'd0);

        // Watchdog with Q stuck at 9.
        stuck = 1'b1;
        REQ_A = 1'b1; VAL_A = 4'd4; STEP3_A = 1'b0;
        g = cyc + 1;
        expect_ev(EV_ERR, g + 21);
        for (int i = 0; i < 21; i++) begin
            tick();
            chk("wd_running", {29'd0, GNT_A, ERR, DONE_A}, 32'd4);
        end
        tick();
        chk("wd_err", {29'd0, GNT_A, ERR, DONE_A}, 32'd2);
        REQ_A = 1'b0;
        tick();
        chk("wd_after", {29'd0, GNT_A, ERR, DONE_A}, 32'd0);
        stuck = 1'b0;

        tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_contador.md
Name: arbitro_contador

Overview:
Round-robin controller that shares one `contador` instance between two requesters, A and B.
Each requester asks for a countdown of VAL steps, by 1 or by 3. The controller grants the counter, loads VAL through D/MODO, drives down-count modes until Q reaches 0, pulses DONE to the owner, then releases the counter.
It sits between the requesting logic and the counter's CLK/ENB/MODO/D/Q pins.
A watchdog flags a counter that fails to reach 0.

Parameters:
WIDTH, 4, counter width; VAL_x, D and Q are WIDTH bits.
WDOG, 20, maximum cycles in COUNT before ERR; must be greater than 2^WIDTH.

Ports:
CLK  in  1  clock; all state changes on the rising edge.
RESET_L  in  1  asynchronous, active-low reset.
REQ_A  in  1  requester A wants the counter; held high until DONE_A, dropping it aborts.
REQ_B  in  1  same, requester B.
VAL_A  in  WIDTH  countdown value for A, sampled at grant.
VAL_B  in  WIDTH  countdown value for B, sampled at grant.
STEP3_A  in  1  A requests step-by-3 mode, sampled at grant.
STEP3_B  in  1  same, B.
Q  in  WIDTH  counter output, fed back from `contador`.
GNT_A  out  1  A owns the counter.
GNT_B  out  1  B owns the counter.
DONE_A  out  1  one-cycle pulse: A's countdown finished.
DONE_B  out  1  same, B.
ERR  out  1  one-cycle pulse: watchdog expired.
ENB  out  1  counter enable.
MODO  out  2  counter mode; 00 up, 01 down-1, 10 down-3, 11 load D.
D  out  WIDTH  counter load value.

Behaviour:
- Reset (RESET_L low, asynchronous): state IDLE; GNT_A, GNT_B, DONE_A, DONE_B, ERR, ENB = 0; MODO = 00; D = 0; priority pointer = A; latched value and step bit = 0.
- All outputs are decoded from registered state and latched data. Exception: ENB and MODO in COUNT also depend on Q. No combinational path exists from REQ, VAL or STEP3 to any output.
- States: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - ENB = 0.
  - On an edge with exactly one REQ high, grant that requester.
  - With both REQ high, grant the requester the pointer names.
  - At grant: latch VAL/STEP3, set GNT, go to LOAD.
- LOAD (one cycle): ENB = 1, MODO = 11, D = latched VAL. The next edge goes to COUNT, and Q = VAL after that edge.
- COUNT:
  - If Q == 0: ENB = 0 and go to DONE.
  - Else if step3 and Q >= 3: ENB = 1, MODO = 10.
  - Else: ENB = 1, MODO = 01.
  - Q therefore never wraps.
  - Step count = VAL with step-by-1; floor(VAL/3) + VAL mod 3 with step-by-3.
- DONE (one cycle): ENB = 0, DONE of the owner = 1, GNT still high. Next edge: GNT = 0, pointer = other requester, go to IDLE. Re-grant is possible from the following edge.
- Timing: grant at edge g; load edge g+1; Q = 0 after edge g+1+steps; DONE high after edge g+2+steps.
- VAL = 0: COUNT sees Q = 0 immediately, so DONE arrives after edge g+2.
- Abort:
  - Owner's REQ low, sampled in LOAD or COUNT: next state IDLE, GNT = 0, ENB = 0, no DONE, pointer = other requester.
  - REQ low during DONE is ignored.
- Watchdog:
  - A cycle counter clears on entering COUNT.
  - If it reaches WDOG while still in COUNT: ERR pulses one cycle, then treat as abort (IDLE, no DONE, pointer toggles).
- The non-owner's REQ is ignored until IDLE; it is not queued beyond being held high.
- Reset mid-operation: outputs return to reset values at once; the counter's Q is not touched.

Decomposition:
- Shared package holds:
  - MODO encodings: MODO_UP = 00, MODO_DN1 = 01, MODO_DN3 = 10, MODO_LOAD = 11.
  - State encodings.
  - Requester index constants.
- One sub-module: `arbitro_rr2`, a two-input round-robin grant picker holding the pointer register. The FSM and watchdog stay in `arbitro_contador`.
- The bench instantiates `arbitro_contador` + `contador` (WIDTH = 4) and a tester module.

Test Plan:
- Reset values: assert RESET_L = 0 mid-clock → all outputs 0 and MODO = 00 immediately. Release → IDLE, no GNT.
- Single down-1 request: REQ_A = 1, VAL_A = 5, STEP3_A = 0, seen at edge k → GNT_A at k+1. At k+2: MODO = 11, D = 5, Q = 5. Q then reads 4, 3, 2, 1, 0 after edges k+3 to k+7 with MODO = 01. DONE_A high one cycle after edge k+8. GNT_A low after edge k+9.
- Step-by-3 request: VAL_B = 7, STEP3_B = 1 → MODO sequence 10, 10, 01; Q = 7, 4, 1, 0. DONE_B appears 3 count cycles after load; Q never wraps.
- Simultaneous requests: REQ_A = REQ_B = 1 from reset → A served first, then B. A second simultaneous round grants A again, since the pointer has returned to A. A VAL_A = 0 grant gives DONE_A two edges after grant.
- Abort and reset: drop REQ_A while Q = 3 → GNT_A = 0 next edge, ENB = 0, no DONE_A, pending REQ_B granted the following edge. Separately, pull RESET_L low while in COUNT → all outputs zero and pointer = A.
- Watchdog: replace `contador` with a stuck-Q model (Q = 9 constant) → ERR pulses once WDOG (20) cycles after COUNT entry, then GNT drops and no DONE is issued.
